// File: rtl/hwpf_req_arbiter.sv
// ---------------------------------------------------------------------------
// hwpf_req_arbiter
//
// Collects prefetch requests from NUM_SRC hardware prefetchers, buffers one
// request per source and issues them one at a time, round-robin, to the
// hpdcache prefetch request port through an output register.
//
// Optional feature (compile-time macro HWPF_ARB_DEDUP_EN):
//   When defined, the line address of the most recently loaded request is
//   remembered and a selected request for that same line is discarded
//   instead of issued (counted in dropped_cnt_o). When undefined, every
//   request is issued and dropped_cnt_o is tied to zero.
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   flush_i            discard all buffered / pending prefetches
//   lock_i             freeze arbitration (no new output loads)
//   src_valid_i        per-source request valid
//   src_ready_o        per-source ready (slot empty and not flushing)
//   src_req_i          per-source request (packed array of hpdcache_req_t)
//   dcache_req_valid_o request valid to hpdcache
//   dcache_req_ready_i hpdcache accepts request
//   dcache_req_o       request to hpdcache
//   issued_cnt_o       saturating count of handshakes with hpdcache
//   dropped_cnt_o      saturating count of requests discarded by dedup
// ---------------------------------------------------------------------------

package hwpf_req_arbiter_pkg;

    localparam int unsigned HPDCACHE_PA_W = 40;

    typedef struct packed {
        logic [HPDCACHE_PA_W-1:0] addr;
        logic [2:0]               size;
        logic [7:0]               tid;
        logic                     need_rsp;
    } hpdcache_req_t;

endpackage

module hwpf_req_arbiter
    import hwpf_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 2,
    parameter int unsigned LINE_OFFSET_W = 6,
    parameter int unsigned ADDR_W        = 40,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         lock_i,
    input  logic          [NUM_SRC-1:0]  src_valid_i,
    output logic          [NUM_SRC-1:0]  src_ready_o,
    input  hpdcache_req_t [NUM_SRC-1:0]  src_req_i,
    output logic                         dcache_req_valid_o,
    input  logic                         dcache_req_ready_i,
    output hpdcache_req_t                dcache_req_o,
    output logic          [CNT_W-1:0]    issued_cnt_o,
    output logic          [CNT_W-1:0]    dropped_cnt_o
);

    localparam int unsigned PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned IDX_W  = PTR_W + 1;
    localparam int unsigned LINE_W = ADDR_W - LINE_OFFSET_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic          [NUM_SRC-1:0] slot_valid;
    hpdcache_req_t [NUM_SRC-1:0] slot_req;
    logic                        out_valid;
    hpdcache_req_t               out_req;
    logic          [PTR_W-1:0]   rr_ptr;
    logic          [PTR_W-1:0]   rr_next;
    logic          [CNT_W-1:0]   issued_cnt;
    logic          [CNT_W-1:0]   dropped_cnt;

    logic          [NUM_SRC-1:0] accept;
    logic                        sel_found;
    logic          [PTR_W-1:0]   sel_idx;
    hpdcache_req_t               sel_req;
    logic                        handshake;
    logic                        can_load;
    logic                        drop;
    logic                        do_load;

    // Ready depends only on slot state and flush, never on the downstream
    // ready, so a slot drained this cycle is refillable only next cycle.
    assign src_ready_o = ~slot_valid & {NUM_SRC{~flush_i}};
    assign accept      = src_valid_i & src_ready_o;

    // Round-robin scan: first valid slot starting at rr_ptr, wrapping.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx       = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = {1'b0, rr_ptr} + IDX_W'(i);
            if (idx >= IDX_W'(NUM_SRC)) begin
                idx = idx - IDX_W'(NUM_SRC);
            end
            if (!sel_found && slot_valid[idx[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx[PTR_W-1:0];
            end
        end
    end

    assign sel_req = slot_req[sel_idx];
    assign rr_next = (sel_idx == PTR_W'(NUM_SRC - 1)) ? '0 : sel_idx + 1'b1;

    assign handshake = out_valid & dcache_req_ready_i;
    // A slot is consumed (loaded or discarded) only when the output register
    // is free or frees up this cycle, so a presented request is never lost.
    assign can_load  = ~lock_i & ~flush_i & (~out_valid | dcache_req_ready_i) & sel_found;
    assign do_load   = can_load & ~drop;

`ifdef HWPF_ARB_DEDUP_EN
    logic              last_valid;
    logic [LINE_W-1:0] last_line;

    assign drop = can_load & last_valid &
                  (sel_req.addr[ADDR_W-1:LINE_OFFSET_W] == last_line);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_valid  <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            if (drop) begin
                dropped_cnt <= sat_inc(dropped_cnt);
            end
            if (flush_i) begin
                last_valid <= 1'b0;
            end else if (do_load) begin
                last_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_load) begin
            last_line <= sel_req.addr[ADDR_W-1:LINE_OFFSET_W];
        end
    end
`else
    assign drop        = 1'b0;
    assign dropped_cnt = '0;
`endif

    // Control state: slot occupancy, output register, pointer, counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid <= '0;
            out_valid  <= 1'b0;
            out_req    <= '0;
            rr_ptr     <= '0;
            issued_cnt <= '0;
        end else begin
            if (handshake) begin
                issued_cnt <= sat_inc(issued_cnt);
            end
            if (flush_i) begin
                slot_valid <= '0;
                out_valid  <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (accept[i]) begin
                        slot_valid[i] <= 1'b1;
                    end else if (can_load && (sel_idx == PTR_W'(i))) begin
                        slot_valid[i] <= 1'b0;
                    end
                end
                if (can_load) begin
                    rr_ptr <= rr_next;
                end
                if (do_load) begin
                    out_valid <= 1'b1;
                    out_req   <= sel_req;
                end else if (handshake) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // Slot payload: written on accept only, qualified by slot_valid.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                slot_req[i] <= src_req_i[i];
            end
        end
    end

    assign dcache_req_valid_o = out_valid;
    assign dcache_req_o       = out_req;
    assign issued_cnt_o       = issued_cnt;
    assign dropped_cnt_o      = dropped_cnt;

endmodule
